// File: rtl/system_onchip_mem_pkg.sv
// Shared constants and FSM encoding for the on-chip memory burst front-end.
package system_onchip_mem_pkg;

   localparam int MEM_DEPTH  = 10240;
   localparam int MEM_ADDR_W = 14;
   localparam int MAX_BURST  = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BURST = 2'd2
   } burst_state_e;

endpackage

// File: rtl/system_onchip_mem_burst_ctr.sv
// Beat address / remaining-beat counter with a sticky out-of-range flag that
// blocks every beat of a burst from the first one that crosses DEPTH.
module system_onchip_mem_burst_ctr
   import system_onchip_mem_pkg::*;
#(
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int BURST_W = 4,
   parameter int DEPTH   = MEM_DEPTH
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load_i,
   input  logic               adv_i,
   input  logic [ADDR_W-1:0]  load_addr_i,
   input  logic [BURST_W-1:0] load_cnt_i,
   input  logic               load_oob_i,
   output logic [ADDR_W-1:0]  addr_o,
   output logic               last_o,
   output logic               oob_o
);

   // One extra bit so an address past the top of the map never wraps back in range.
   logic [ADDR_W:0]    base_cnt_q, base_cnt_d;
   logic [BURST_W-1:0] rem_cnt_q, rem_cnt_d;
   logic               burst_oob_q, burst_oob_d;

   assign addr_o = base_cnt_q[ADDR_W-1:0];
   assign last_o = (rem_cnt_q == BURST_W'(1));
   assign oob_o  = burst_oob_q | (base_cnt_q >= (ADDR_W+1)'(DEPTH));

   always_comb begin
      // NOTE: every output gets a default first, so no branch can infer a latch.
      base_cnt_d  = base_cnt_q;
      rem_cnt_d   = rem_cnt_q;
      burst_oob_d = burst_oob_q;
      if (load_i) begin
         base_cnt_d  = {1'b0, load_addr_i} + (ADDR_W+1)'(1);
         rem_cnt_d   = load_cnt_i - BURST_W'(1);
         burst_oob_d = load_oob_i & (load_cnt_i > BURST_W'(1));
      end else if (adv_i) begin
         base_cnt_d  = base_cnt_q + (ADDR_W+1)'(1);
         rem_cnt_d   = rem_cnt_q - BURST_W'(1);
         burst_oob_d = oob_o & ~last_o;
      end
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_cnt_q  <= '0;
         rem_cnt_q   <= '0;
         burst_oob_q <= 1'b0;
      end else begin
         base_cnt_q  <= base_cnt_d;
         rem_cnt_q   <= rem_cnt_d;
         burst_oob_q <= burst_oob_d;
      end
   end

endmodule

// File: rtl/system_onchip_mem_burst_adapter.sv
// Avalon-MM burst front-end: splits read/write bursts into one memory access
// per cycle, returns read data with readdatavalid and blocks beats past DEPTH.
module system_onchip_mem_burst_adapter
   import system_onchip_mem_pkg::*;
#(
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int DATA_W  = 32,
   parameter int BE_W    = DATA_W / 8,
   parameter int DEPTH   = MEM_DEPTH,
   parameter int BURST_W = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [ADDR_W-1:0]  s_address,
   input  logic [BURST_W-1:0] s_burstcount,
   input  logic               s_read,
   input  logic               s_write,
   input  logic [DATA_W-1:0]  s_writedata,
   input  logic [BE_W-1:0]    s_byteenable,
   output logic               s_waitrequest,
   output logic [DATA_W-1:0]  s_readdata,
   output logic               s_readdatavalid,
   output logic               oob_err,
   output logic [ADDR_W-1:0]  m_address,
   output logic [BE_W-1:0]    m_byteenable,
   output logic               m_chipselect,
   output logic               m_write,
   output logic [DATA_W-1:0]  m_writedata,
   output logic               m_clken,
   input  logic [DATA_W-1:0]  m_readdata
);

   burst_state_e       state_q, state_d;
   logic               ready_q, ready_d;
   logic               rdv_q, rdv_d;
   logic               oob_q, oob_d;

   logic [BURST_W-1:0] burst_eff;
   logic               first_oob;
   logic               issue, issue_wr, beat_oob;
   logic [ADDR_W-1:0]  beat_addr;
   logic               ctr_load, ctr_adv, ctr_last, ctr_oob;
   logic [ADDR_W-1:0]  ctr_addr;

   always_comb begin
      burst_eff = s_burstcount;
      if (s_burstcount == '0) begin
         burst_eff = BURST_W'(1);
      end else if (s_burstcount > BURST_W'(MAX_BURST)) begin
         burst_eff = BURST_W'(MAX_BURST);
      end
   end

   assign first_oob = ({1'b0, s_address} >= (ADDR_W+1)'(DEPTH));

   system_onchip_mem_burst_ctr #(
      .ADDR_W  (ADDR_W),
      .BURST_W (BURST_W),
      .DEPTH   (DEPTH)
   ) u_ctr (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_i      (ctr_load),
      .adv_i       (ctr_adv),
      .load_addr_i (s_address),
      .load_cnt_i  (burst_eff),
      .load_oob_i  (first_oob),
      .addr_o      (ctr_addr),
      .last_o      (ctr_last),
      .oob_o       (ctr_oob)
   );

   always_comb begin
      state_d   = state_q;
      issue     = 1'b0;
      issue_wr  = 1'b0;
      beat_addr = ctr_addr;
      beat_oob  = ctr_oob;
      ctr_load  = 1'b0;
      ctr_adv   = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Beat 0 goes straight to the memory in the accepting cycle.
            if (ready_q && (s_read || s_write)) begin
               issue     = 1'b1;
               issue_wr  = ~s_read;
               beat_addr = s_address;
               beat_oob  = first_oob;
               ctr_load  = 1'b1;
               if (burst_eff > BURST_W'(1)) begin
                  state_d = s_read ? RD_BURST : WR_BURST;
               end
            end
         end
         RD_BURST: begin
            issue   = 1'b1;
            ctr_adv = 1'b1;
            if (ctr_last) state_d = IDLE;
         end
         WR_BURST: begin
            if (s_write) begin
               issue    = 1'b1;
               issue_wr = 1'b1;
               ctr_adv  = 1'b1;
               if (ctr_last) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ready_d = 1'b1;
   assign rdv_d   = issue & ~issue_wr;
   assign oob_d   = issue & beat_oob;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         rdv_q   <= 1'b0;
         oob_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         rdv_q   <= rdv_d;
         oob_q   <= oob_d;
      end
   end

   assign s_waitrequest   = ~ready_q | (state_q == RD_BURST);
   assign s_readdatavalid = rdv_q;
   // Blocked read beats still complete, but never expose stale memory output.
   assign s_readdata      = (rdv_q && !oob_q) ? m_readdata : '0;
   assign oob_err         = oob_q;

   assign m_chipselect = issue & ~beat_oob;
   assign m_write      = issue & ~beat_oob & issue_wr;
   assign m_address    = beat_addr;
   assign m_byteenable = s_byteenable;
   assign m_writedata  = s_writedata;
   assign m_clken      = ready_q;

endmodule

// File: tb/tb_system_onchip_mem_burst_adapter.sv
// Directed bench for the burst adapter with a behavioural 32-bit memory behind it.
module tb_system_onchip_mem_burst_adapter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [13:0] s_address;
   logic [3:0]  s_burstcount;
   logic        s_read, s_write;
   logic [31:0] s_writedata;
   logic [3:0]  s_byteenable;
   logic        s_waitrequest;
   logic [31:0] s_readdata;
   logic        s_readdatavalid;
   logic        oob_err;
   logic [13:0] m_address;
   logic [3:0]  m_byteenable;
   logic        m_chipselect, m_write, m_clken;
   logic [31:0] m_writedata;
   logic [31:0] m_readdata = 32'h0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   system_onchip_mem_burst_adapter dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .s_address       (s_address),
      .s_burstcount    (s_burstcount),
      .s_read          (s_read),
      .s_write         (s_write),
      .s_writedata     (s_writedata),
      .s_byteenable    (s_byteenable),
      .s_waitrequest   (s_waitrequest),
      .s_readdata      (s_readdata),
      .s_readdatavalid (s_readdatavalid),
      .oob_err         (oob_err),
      .m_address       (m_address),
      .m_byteenable    (m_byteenable),
      .m_chipselect    (m_chipselect),
      .m_write         (m_write),
      .m_writedata     (m_writedata),
      .m_clken         (m_clken),
      .m_readdata      (m_readdata)
   );

   // Memory model: preloads on its first edge, registered read, byte-lane writes.
   logic [31:0] mem [0:16383];
   bit          loaded = 1'b0;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
         for (int i = 0; i < 8; i++) mem[14'h0100 + i] = 32'hA500_0000 + i;
         mem[14'h0200] = 32'h5A5A_0200;
         mem[14'h0000] = 32'h0BAD_F00D;
         mem[14'h3000] = 32'hFFFF_FFFF;
         loaded = 1'b1;
      end else if (m_clken && m_chipselect) begin
         m_readdata <= mem[m_address];
         if (m_write) begin
            for (int b = 0; b < 4; b++)
               if (m_byteenable[b]) mem[m_address][8*b +: 8] = m_writedata[8*b +: 8];
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({s_waitrequest, s_readdatavalid, oob_err, m_chipselect, m_write, m_clken} !== 6'b100000) begin
            bad++;
            $display("FAIL rst_strobes: got %b want 100000",
                     {s_waitrequest, s_readdatavalid, oob_err, m_chipselect, m_write, m_clken});
         end
         total++;
         if (s_readdata !== 32'h0) begin
            bad++; $display("FAIL rst_rdata: got %h want 00000000", s_readdata);
         end
      end
      @(posedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      total++;
      if ({s_waitrequest, m_clken} !== 2'b10) begin
         bad++; $display("FAIL rel_wait_pre_edge: got %b want 10", {s_waitrequest, m_clken});
      end
      step();
      @(negedge clk);
      total++;
      if ({s_waitrequest, m_clken, s_readdatavalid, oob_err} !== 4'b0100) begin
         bad++;
         $display("FAIL rel_wait_post_edge: got %b want 0100",
                  {s_waitrequest, m_clken, s_readdatavalid, oob_err});
      end
   endtask

   task automatic test_single_write_read();
      step();
      s_write = 1'b1; s_address = 14'h0010; s_burstcount = 4'd1;
      s_writedata = 32'hDEAD_BEEF; s_byteenable = 4'hF;
      @(negedge clk);
      total++;
      if ({s_waitrequest, m_chipselect, m_write} !== 3'b011 || m_address !== 14'h0010) begin
         bad++;
         $display("FAIL wr0_drive: got ws/cs/we=%b addr=%h want 011 addr=0010",
                  {s_waitrequest, m_chipselect, m_write}, m_address);
      end
      step();
      s_writedata = 32'h0000_00AA; s_byteenable = 4'h1;
      @(negedge clk);
      total++;
      if ({s_waitrequest, m_chipselect, m_write} !== 3'b011 || m_byteenable !== 4'h1) begin
         bad++;
         $display("FAIL wr1_drive: got ws/cs/we=%b be=%h want 011 be=1",
                  {s_waitrequest, m_chipselect, m_write}, m_byteenable);
      end
      step();
      s_write = 1'b0; s_read = 1'b1;
      @(negedge clk);
      total++;
      if ({s_waitrequest, m_chipselect, m_write} !== 3'b010) begin
         bad++; $display("FAIL rd_drive: got %b want 010", {s_waitrequest, m_chipselect, m_write});
      end
      step();
      s_read = 1'b0;
      @(negedge clk);
      total++;
      if (s_readdatavalid !== 1'b1 || s_readdata !== 32'hDEAD_BEAA) begin
         bad++;
         $display("FAIL rd_data: got v=%b d=%h want v=1 d=deadbeaa", s_readdatavalid, s_readdata);
      end
      step();
      @(negedge clk);
      total++;
      if (s_readdatavalid !== 1'b0) begin
         bad++; $display("FAIL rd_single_valid: got %b want 0", s_readdatavalid);
      end
   endtask

   task automatic test_read_burst8();
      int waits = 0;
      logic [31:0] exp_d;
      step();
      s_read = 1'b1; s_address = 14'h0100; s_burstcount = 4'd8;
      @(negedge clk);
      total++;
      if (s_waitrequest !== 1'b0 || m_chipselect !== 1'b1 || m_address !== 14'h0100) begin
         bad++;
         $display("FAIL b8_accept: got ws=%b cs=%b addr=%h want 0 1 0100",
                  s_waitrequest, m_chipselect, m_address);
      end
      for (int c = 1; c <= 9; c++) begin
         step();
         if (c == 1) begin s_address = 14'h0200; s_burstcount = 4'd1; end
         if (c == 9) s_read = 1'b0;
         @(negedge clk);
         if (s_waitrequest) waits++;
         if (c <= 7) begin
            total++;
            if (m_chipselect !== 1'b1 || m_address !== 14'(14'h0100 + c)) begin
               bad++;
               $display("FAIL b8_beat%0d: got cs=%b addr=%h want 1 %h",
                        c, m_chipselect, m_address, 14'(14'h0100 + c));
            end
         end
         if (c == 8) begin
            total++;
            if ({s_waitrequest, m_chipselect} !== 2'b01 || m_address !== 14'h0200) begin
               bad++;
               $display("FAIL b8_next_accept: got ws/cs=%b addr=%h want 01 0200",
                        {s_waitrequest, m_chipselect}, m_address);
            end
         end
         exp_d = (c <= 8) ? 32'hA500_0000 + 32'(c - 1) : 32'h5A5A_0200;
         total++;
         if (s_readdatavalid !== 1'b1 || s_readdata !== exp_d) begin
            bad++;
            $display("FAIL b8_ret%0d: got v=%b d=%h want v=1 d=%h", c, s_readdatavalid, s_readdata, exp_d);
         end
      end
      total++;
      if (waits != 7) begin
         bad++; $display("FAIL b8_wait_cycles: got %0d want 7", waits);
      end
      step();
      @(negedge clk);
      total++;
      if (s_readdatavalid !== 1'b0) begin
         bad++; $display("FAIL b8_tail: got v=%b want 0", s_readdatavalid);
      end
   endtask

   task automatic test_write_burst_oob();
      step();
      s_write = 1'b1; s_address = 14'h27FE; s_burstcount = 4'd4;
      s_writedata = 32'h1111_1111; s_byteenable = 4'hF;
      @(negedge clk);
      total++;
      if ({s_waitrequest, m_chipselect, m_write} !== 3'b011 || m_address !== 14'h27FE) begin
         bad++;
         $display("FAIL wb_beat0: got %b addr=%h want 011 27fe", {s_waitrequest, m_chipselect, m_write}, m_address);
      end
      step();
      s_writedata = 32'h2222_2222;
      @(negedge clk);
      total++;
      if ({m_chipselect, m_write, oob_err} !== 3'b110 || m_address !== 14'h27FF) begin
         bad++;
         $display("FAIL wb_beat1: got cs/we/oob=%b addr=%h want 110 27ff", {m_chipselect, m_write, oob_err}, m_address);
      end
      step();
      s_write = 1'b0;
      @(negedge clk);
      total++;
      if ({s_waitrequest, m_chipselect, m_write, oob_err} !== 4'b0000) begin
         bad++; $display("FAIL wb_gap: got %b want 0000", {s_waitrequest, m_chipselect, m_write, oob_err});
      end
      step();
      s_write = 1'b1; s_writedata = 32'h3333_3333;
      @(negedge clk);
      total++;
      if ({m_chipselect, m_write, oob_err} !== 3'b000) begin
         bad++; $display("FAIL wb_beat2: got cs/we/oob=%b want 000", {m_chipselect, m_write, oob_err});
      end
      step();
      s_writedata = 32'h4444_4444;
      @(negedge clk);
      total++;
      if ({m_chipselect, m_write, oob_err} !== 3'b001) begin
         bad++; $display("FAIL wb_beat3: got cs/we/oob=%b want 001", {m_chipselect, m_write, oob_err});
      end
      step();
      s_write = 1'b0; s_read = 1'b1; s_address = 14'h27FE; s_burstcount = 4'd2;
      @(negedge clk);
      total++;
      if ({oob_err, s_waitrequest, m_chipselect, m_write} !== 4'b1010 || m_address !== 14'h27FE) begin
         bad++;
         $display("FAIL wb_rb_accept: got oob/ws/cs/we=%b addr=%h want 1010 27fe",
                  {oob_err, s_waitrequest, m_chipselect, m_write}, m_address);
      end
      step();
      s_read = 1'b0;
      @(negedge clk);
      total++;
      if ({oob_err, s_readdatavalid} !== 2'b01 || s_readdata !== 32'h1111_1111) begin
         bad++;
         $display("FAIL wb_rb0: got oob/v=%b d=%h want 01 11111111", {oob_err, s_readdatavalid}, s_readdata);
      end
      step();
      @(negedge clk);
      total++;
      if ({oob_err, s_readdatavalid} !== 2'b01 || s_readdata !== 32'h2222_2222) begin
         bad++;
         $display("FAIL wb_rb1: got oob/v=%b d=%h want 01 22222222", {oob_err, s_readdatavalid}, s_readdata);
      end
      total++;
      if (mem[14'h2800] !== 32'h0 || mem[14'h2801] !== 32'h0) begin
         bad++;
         $display("FAIL wb_blocked_mem: got %h %h want 00000000 00000000", mem[14'h2800], mem[14'h2801]);
      end
   endtask

   task automatic test_read_oob();
      int cs_seen = 0;
      int oob_seen = 0;
      step();
      s_read = 1'b1; s_address = 14'h3000; s_burstcount = 4'd3;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin
            step();
            s_read = 1'b0;
         end
         @(negedge clk);
         if (m_chipselect) cs_seen++;
         if (oob_err) oob_seen++;
         if (c >= 1 && c <= 3) begin
            total++;
            if (s_readdatavalid !== 1'b1 || s_readdata !== 32'h0) begin
               bad++;
               $display("FAIL ro_ret%0d: got v=%b d=%h want v=1 d=00000000", c, s_readdatavalid, s_readdata);
            end
         end
      end
      total++;
      if (cs_seen != 0 || oob_seen != 3) begin
         bad++; $display("FAIL ro_counts: got cs=%0d oob=%0d want cs=0 oob=3", cs_seen, oob_seen);
      end
   endtask

   task automatic test_reset_mid_burst();
      int rdv_seen = 0;
      int cs_seen = 0;
      step();
      s_read = 1'b1; s_address = 14'h0100; s_burstcount = 4'd8;
      @(negedge clk);
      step();
      s_read = 1'b0;
      @(negedge clk);
      total++;
      if (s_readdatavalid !== 1'b1 || s_readdata !== 32'hA500_0000) begin
         bad++; $display("FAIL rm_ret0: got v=%b d=%h want v=1 d=a5000000", s_readdatavalid, s_readdata);
      end
      step();
      step();
      reset_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if ({s_waitrequest, s_readdatavalid, oob_err, m_chipselect, m_write, m_clken} !== 6'b100000) begin
            bad++;
            $display("FAIL rm_in_reset%0d: got %b want 100000", i,
                     {s_waitrequest, s_readdatavalid, oob_err, m_chipselect, m_write, m_clken});
         end
         step();
      end
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         @(negedge clk);
         if (s_readdatavalid) rdv_seen++;
         if (m_chipselect) cs_seen++;
      end
      total++;
      if (rdv_seen != 0 || cs_seen != 0 || s_waitrequest !== 1'b0) begin
         bad++;
         $display("FAIL rm_after: got valids=%0d cs=%0d ws=%b want 0 0 0", rdv_seen, cs_seen, s_waitrequest);
      end
      step();
      s_read = 1'b1; s_address = 14'h0000; s_burstcount = 4'd1;
      @(negedge clk);
      total++;
      if ({s_waitrequest, m_chipselect} !== 2'b01 || m_address !== 14'h0000) begin
         bad++;
         $display("FAIL rm_fresh_accept: got ws/cs=%b addr=%h want 01 0000", {s_waitrequest, m_chipselect}, m_address);
      end
      step();
      s_read = 1'b0;
      @(negedge clk);
      total++;
      if (s_readdatavalid !== 1'b1 || s_readdata !== 32'h0BAD_F00D) begin
         bad++; $display("FAIL rm_fresh_data: got v=%b d=%h want v=1 d=0badf00d", s_readdatavalid, s_readdata);
      end
      step();
      @(negedge clk);
      total++;
      if (s_readdatavalid !== 1'b0) begin
         bad++; $display("FAIL rm_fresh_tail: got v=%b want 0", s_readdatavalid);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      s_address = '0; s_burstcount = '0; s_read = 1'b0; s_write = 1'b0;
      s_writedata = '0; s_byteenable = '0;
      test_reset();
      test_single_write_read();
      test_read_burst8();
      test_write_burst_oob();
      test_read_oob();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within 100000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/system_onchip_mem_burst_adapter.md
# system_onchip_mem_burst_adapter

Avalon-MM burst front-end for the 10240 x 32 single-port on-chip memory. It sits directly upstream of the memory and accepts pipelined read/write bursts from the system interconnect. It converts each burst into one single-word memory access per cycle and returns read data with `readdatavalid`. Beats that fall outside the populated depth are blocked from the memory and flagged.

## Interface
- `ADDR_W`, 14: word-address width, shared with the memory.
- `DATA_W`, 32: data width.
- `BE_W`, 4: byte-enable width (`DATA_W/8`).
- `DEPTH`, 10240: number of populated words. Word addresses `>= DEPTH` are out of range.
- `BURST_W`, 4: burstcount width. Maximum legal burst is 8.

- `clk` in 1: single clock for the block and the memory.
- `reset_n` in 1: asynchronous, active-low reset.
- `s_address` in `ADDR_W`: word address of the first beat.
- `s_burstcount` in `BURST_W`: beats in the burst. 0 is treated as 1.
- `s_read`, `s_write` in 1: command strobes. Never both high in the same cycle.
- `s_writedata` in `DATA_W`, `s_byteenable` in `BE_W`: per-beat write data and lanes.
- `s_waitrequest` out 1: stall to the upstream master.
- `s_readdata` out `DATA_W`, `s_readdatavalid` out 1: read return path.
- `oob_err` out 1: one-cycle pulse for each blocked out-of-range beat.
- `m_address` out `ADDR_W`, `m_byteenable` out `BE_W`, `m_chipselect` out 1, `m_write` out 1, `m_writedata` out `DATA_W`, `m_clken` out 1: memory-side command.
- `m_readdata` in `DATA_W`: memory read data, valid one cycle after its address.

## Operation
- FSM states: `IDLE`, `RD_BURST`, `WR_BURST`.
- Registered state: `base_cnt` (next beat address, `ADDR_W+1` bits, no wrap), `rem_cnt` (beats left, `BURST_W` bits), `burst_oob` (sticky per burst), `rdv_q`, `oob_q`, `ready_q`.
- **`IDLE`, read accepted** (`s_read & ~s_waitrequest`):
  - Beat 0 is issued in the same cycle with `m_address = s_address`.
  - If burstcount > 1: go to `RD_BURST`, with `base_cnt = s_address+1` and `rem_cnt = burstcount-1`.
- **`RD_BURST`**:
  - `s_waitrequest` = 1.
  - One beat is issued per cycle from `base_cnt`, then `base_cnt` increments and `rem_cnt` decrements.
  - Exit to `IDLE` in the cycle the last beat issues.
  - Upstream commands are not accepted while in this state.
- **`IDLE`, write accepted**:
  - Beat 0 is written at `s_address`.
  - If burstcount > 1: go to `WR_BURST`.
- **`WR_BURST`**:
  - `s_waitrequest` = 0.
  - Each cycle with `s_write` high writes to `base_cnt`, then increments it. Cycles with `s_write` low are idle and do not advance the burst.
  - `s_read` in this state is ignored (protocol violation).
  - Exit to `IDLE` on the last beat.
- **Memory drive**: `m_chipselect` = 1 on every issued in-range beat. `m_write` = 1 only on in-range write beats. Byte lanes and data pass through unchanged.
- **Out of range**: a beat is out of range if its address `>= DEPTH`, or if `burst_oob` is already set.
  - `m_chipselect` and `m_write` are forced to 0 for that beat.
  - `oob_err` pulses one cycle later (registered).
  - `burst_oob` is set and stays set until the burst ends, so a burst that crosses `DEPTH` is blocked from that beat onward.
  - Out-of-range read beats still return `s_readdatavalid` = 1, with `s_readdata` = 0.
- **Memory clock enable**: `m_clken` = `ready_q`.

## Timing
- Reset values (`reset_n` low):
  - state = `IDLE`; counters, `burst_oob`, `rdv_q`, `oob_q`, `ready_q` = 0.
  - `s_waitrequest` = 1, `s_readdatavalid` = 0, `s_readdata` = 0, `oob_err` = 0.
  - All `m_*` strobes = 0.
- `ready_q` sets on the first `clk` edge after `reset_n` deasserts. `s_waitrequest = ~ready_q | (state == RD_BURST)`.
- Read latency:
  - Beat issued at edge N; `s_readdatavalid` high in cycle N+1, with `s_readdata = m_readdata`.
  - A burst of B beats returns B consecutive valids with no gaps.
- A new command may be accepted in the cycle after the last read beat issues, while that beat's data is still returning. Returned data stays in order.
- Write latency: a write is committed at the edge on which it is accepted. No response is returned.
- Reset mid-burst:
  - The burst is abandoned immediately and `rem_cnt` is cleared.
  - Pending `s_readdatavalid` and `oob_err` are dropped.
  - No memory strobe is generated while `reset_n` is low.
- `s_burstcount` > 8 is clamped to 8.

## Structure
- Package `system_onchip_mem_pkg`:
  - FSM state enum.
  - `MEM_DEPTH` = 10240, `MEM_ADDR_W` = 14, `MAX_BURST` = 8.
- One sub-module, `system_onchip_mem_burst_ctr`:
  - Holds `base_cnt`, `rem_cnt`, `burst_oob`.
  - Inputs: load, advance.
  - Outputs: current address, last-beat flag, out-of-range flag.
- The top level holds the FSM, the `rdv_q`/`oob_q` pipeline and the memory drive logic.

## Test plan
- **Reset release**: `s_waitrequest` = 1 while `reset_n` = 0 and for the first edge after release, then 0. `s_readdatavalid` and `oob_err` stay 0 throughout.
- **Single write then read**: write 0xDEADBEEF with BE 0xF at address 0x0010, then write 0x000000AA with BE 0x1 to the same address. Read of 0x0010 returns 0xDEADBEAA one cycle after acceptance.
- **8-beat read burst from 0x0100**:
  - `s_waitrequest` is high for 7 cycles.
  - Eight contiguous valids return data from 0x0100 to 0x0107 in order.
  - A new read accepted right after the last beat issues returns immediately after those eight.
- **Write burst crossing `DEPTH`**: 4 beats at 0x27FE.
  - Beats 0-1 are written.
  - Beats 2-3 keep `m_write` = 0 and produce two `oob_err` pulses.
  - A readback of 0x27FE/0x27FF matches the written data.
- **Read burst fully out of range**: 3 beats at 0x3000 return three valids with data 0, three `oob_err` pulses and `m_chipselect` never asserted.
- **Reset mid-burst**: assert `reset_n` = 0 during beat 3 of an 8-beat read. Afterwards there are no further valids, state is `IDLE`, and a fresh read of 0x0000 works normally.
